// File: rtl/fp_class_pkg.sv
// Shared class-mask layout, flag layout, decode record and format detection
// for the floating-point classifier.
package fp_class_pkg;

    localparam int CLASS_W = 10;

    localparam logic [3:0] CLASS_NEG_INF  = 4'd0;
    localparam logic [3:0] CLASS_NEG_NORM = 4'd1;
    localparam logic [3:0] CLASS_NEG_SUB  = 4'd2;
    localparam logic [3:0] CLASS_NEG_ZERO = 4'd3;
    localparam logic [3:0] CLASS_POS_ZERO = 4'd4;
    localparam logic [3:0] CLASS_POS_SUB  = 4'd5;
    localparam logic [3:0] CLASS_POS_NORM = 4'd6;
    localparam logic [3:0] CLASS_POS_INF  = 4'd7;
    localparam logic [3:0] CLASS_SNAN     = 4'd8;
    localparam logic [3:0] CLASS_QNAN     = 4'd9;

    localparam int FLAG_SNAN = 0;
    localparam int FLAG_QNAN = 1;
    localparam int FLAG_INF  = 2;
    localparam int FLAG_SUB  = 3;

    typedef enum logic [2:0] {
        FMT_IEEE,
        FMT_E4M3,
        FMT_E2M3,
        FMT_E3M2,
        FMT_E2M1
    } fp_fmt_e;

    typedef struct packed {
        logic sign;
        logic exp_zero;
        logic exp_ones;
        logic mant_zero;
        logic mant_msb;
        logic mant_ones;
    } lane_dec_t;

    // Anything that is not one of the MX small formats follows IEEE rules (E5M2 included).
    function automatic fp_fmt_e fmt_of(input int exp_w, input int mant_w);
        if (exp_w == 4 && mant_w == 3) return FMT_E4M3;
        if (exp_w == 2 && mant_w == 3) return FMT_E2M3;
        if (exp_w == 3 && mant_w == 2) return FMT_E3M2;
        if (exp_w == 2 && mant_w == 1) return FMT_E2M1;
        return FMT_IEEE;
    endfunction

endpackage

// File: rtl/fp_lane_classify.sv
// Single-lane field decode (feeds stage 1) and class encode from the
// registered decode (feeds stage 2).
module fp_lane_classify
    import fp_class_pkg::*;
#(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23
) (
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] operand,
    output lane_dec_t                              dec,
    input  lane_dec_t                              dec_q,
    output logic [CLASS_W-1:0]                     cls
);

    localparam fp_fmt_e FMT = fmt_of(EXPONENT_WIDTH, MANTISSA_WIDTH);

    logic [EXPONENT_WIDTH-1:0] exp_f;
    logic [MANTISSA_WIDTH-1:0] mant_f;
    logic [3:0]                fin_idx;
    logic [3:0]                idx;

    assign exp_f  = operand[EXPONENT_WIDTH+MANTISSA_WIDTH-1:MANTISSA_WIDTH];
    assign mant_f = operand[MANTISSA_WIDTH-1:0];

    assign dec.sign      = operand[EXPONENT_WIDTH+MANTISSA_WIDTH];
    assign dec.exp_zero  = (exp_f == '0);
    assign dec.exp_ones  = &exp_f;
    assign dec.mant_zero = (mant_f == '0);
    assign dec.mant_msb  = mant_f[MANTISSA_WIDTH-1];
    assign dec.mant_ones = &mant_f;

    always_comb begin
        // Finite class; small formats treat an all-ones exponent as normal.
        if (dec_q.exp_zero && dec_q.mant_zero)
            fin_idx = dec_q.sign ? CLASS_NEG_ZERO : CLASS_POS_ZERO;
        else if (dec_q.exp_zero)
            fin_idx = dec_q.sign ? CLASS_NEG_SUB : CLASS_POS_SUB;
        else
            fin_idx = dec_q.sign ? CLASS_NEG_NORM : CLASS_POS_NORM;

        idx = fin_idx;
        case (FMT)
            FMT_IEEE: begin
                if (dec_q.exp_ones) begin
                    if (dec_q.mant_zero)
                        idx = dec_q.sign ? CLASS_NEG_INF : CLASS_POS_INF;
                    else if (dec_q.mant_msb)
                        idx = CLASS_QNAN;
                    else
                        idx = CLASS_SNAN;
                end
            end
            FMT_E4M3: begin
                if (dec_q.exp_ones && dec_q.mant_ones)
                    idx = CLASS_QNAN;
            end
            default: ;
        endcase

        cls      = '0;
        cls[idx] = 1'b1;
    end

endmodule

// File: rtl/float_classify_pipe.sv
// Two-stage, multi-lane FP classifier with valid/ready handshake, sticky
// exception flags and a saturating NaN-lane counter.
module float_classify_pipe
    import fp_class_pkg::*;
#(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int NUM_LANES      = 4,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                                                clk_in,
    input  logic                                                rst_in,
    input  logic                                                in_valid_in,
    output logic                                                in_ready_out,
    input  logic [NUM_LANES*(1+EXPONENT_WIDTH+MANTISSA_WIDTH)-1:0] in_data_in,
    output logic                                                out_valid_out,
    input  logic                                                out_ready_in,
    output logic [NUM_LANES*CLASS_W-1:0]                        out_class_out,
    output logic                                                out_any_nan_out,
    input  logic                                                clr_sticky_in,
    output logic [3:0]                                          sticky_flags_out,
    output logic [COUNT_WIDTH-1:0]                              nan_count_out
);

    localparam int LW = 1 + EXPONENT_WIDTH + MANTISSA_WIDTH;
    localparam int PW = $clog2(NUM_LANES + 1);
    localparam int SW = COUNT_WIDTH + PW;

    logic [2:1]                         vld_pipe;
    logic                               s1_adv;
    logic                               s2_adv;
    logic                               hs;

    lane_dec_t [NUM_LANES-1:0]          dec_d;
    lane_dec_t [NUM_LANES-1:0]          dec_q;
    logic [NUM_LANES-1:0][CLASS_W-1:0]  cls_d;
    logic [NUM_LANES-1:0][CLASS_W-1:0]  cls_q;

    logic                               any_nan_d, any_nan_q;
    logic [3:0]                         flags_d, beat_flags_q;
    logic [PW-1:0]                      nan_cnt_d, nan_cnt_q;
    logic [3:0]                         sticky_q, sticky_next;
    logic [COUNT_WIDTH-1:0]             count_q, count_next, count_base;
    logic [SW-1:0]                      cnt_sum;

    assign s2_adv = !vld_pipe[2] || out_ready_in;
    assign s1_adv = !vld_pipe[1] || s2_adv;
    assign hs     = vld_pipe[2] && out_ready_in;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        fp_lane_classify #(
            .EXPONENT_WIDTH (EXPONENT_WIDTH),
            .MANTISSA_WIDTH (MANTISSA_WIDTH)
        ) u_lane (
            .operand (in_data_in[i*LW +: LW]),
            .dec     (dec_d[i]),
            .dec_q   (dec_q[i]),
            .cls     (cls_d[i])
        );
    end

    always_comb begin
        any_nan_d = 1'b0;
        flags_d   = '0;
        nan_cnt_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            any_nan_d          = any_nan_d | cls_d[i][CLASS_SNAN] | cls_d[i][CLASS_QNAN];
            nan_cnt_d          = nan_cnt_d + PW'(cls_d[i][CLASS_SNAN] | cls_d[i][CLASS_QNAN]);
            flags_d[FLAG_SNAN] = flags_d[FLAG_SNAN] | cls_d[i][CLASS_SNAN];
            flags_d[FLAG_QNAN] = flags_d[FLAG_QNAN] | cls_d[i][CLASS_QNAN];
            flags_d[FLAG_INF]  = flags_d[FLAG_INF] | cls_d[i][CLASS_NEG_INF] | cls_d[i][CLASS_POS_INF];
            flags_d[FLAG_SUB]  = flags_d[FLAG_SUB] | cls_d[i][CLASS_NEG_SUB] | cls_d[i][CLASS_POS_SUB];
        end
    end

    // A clear wipes the old state only; a beat handshaked in the same cycle still lands.
    always_comb begin
        count_base  = clr_sticky_in ? '0 : count_q;
        cnt_sum     = SW'(count_base) + (hs ? SW'(nan_cnt_q) : '0);
        count_next  = (cnt_sum > SW'({COUNT_WIDTH{1'b1}})) ? '1 : cnt_sum[COUNT_WIDTH-1:0];
        sticky_next = (clr_sticky_in ? 4'b0 : sticky_q) | (hs ? beat_flags_q : 4'b0);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld_pipe     <= '0;
            dec_q        <= '0;
            cls_q        <= '0;
            any_nan_q    <= 1'b0;
            beat_flags_q <= '0;
            nan_cnt_q    <= '0;
            sticky_q     <= '0;
            count_q      <= '0;
        end else begin
            if (s1_adv) begin
                vld_pipe[1] <= in_valid_in;
                if (in_valid_in)
                    dec_q <= dec_d;
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    cls_q        <= cls_d;
                    any_nan_q    <= any_nan_d;
                    beat_flags_q <= flags_d;
                    nan_cnt_q    <= nan_cnt_d;
                end
            end
            sticky_q <= sticky_next;
            count_q  <= count_next;
        end
    end

    assign in_ready_out     = s1_adv;
    assign out_valid_out    = vld_pipe[2];
    assign out_class_out    = cls_q;
    assign out_any_nan_out  = any_nan_q;
    assign sticky_flags_out = sticky_q;
    assign nan_count_out    = count_q;

endmodule

// File: doc/float_classify_pipe.md
Name: float_classify_pipe

Overview:
- Multi-lane, two-stage pipelined floating-point classifier. It emits a 10-bit class mask per lane plus sticky exception-style flags and a saturating NaN counter.
- Sits between the FP register-read stage and FPU result/flag writeback; it serves vector FCLASS-type ops and feeds early NaN/subnormal detection to the FP adder/multiplier issue logic.
- Supports IEEE formats and the MX small formats (E4M3, E2M3, E3M2, E2M1) with format-correct special-value rules.

Parameters:
- EXPONENT_WIDTH, 8, exponent field width.
- MANTISSA_WIDTH, 23, mantissa field width (no hidden bit).
- NUM_LANES, 4, independent operands per beat.
- COUNT_WIDTH, 16, width of the saturating NaN-lane counter.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous active-high reset.
- in_valid_in  input  1  input beat valid.
- in_ready_out  output  1  input beat accepted when in_valid_in && in_ready_out.
- in_data_in  input  NUM_LANES*(1+EXPONENT_WIDTH+MANTISSA_WIDTH)  lane i at slice i; each lane is {sign, exponent, mantissa}.
- out_valid_out  output  1  result beat valid.
- out_ready_in  input  1  downstream accepts the result.
- out_class_out  output  NUM_LANES*10  per-lane one-hot class mask.
- out_any_nan_out  output  1  OR over lanes of mask bits 8|9.
- clr_sticky_in  input  1  clear sticky flags and counter.
- sticky_flags_out  output  4  {subnormal_seen, inf_seen, qnan_seen, snan_seen} (bits 3..0).
- nan_count_out  output  COUNT_WIDTH  saturating count of NaN lanes delivered.

Behaviour:
- Interface: one clock, clk_in; reset is synchronous and active-high on rst_in.
- Reset values: all stage valids 0, out_valid_out 0, out_class_out 0, out_any_nan_out 0, sticky_flags_out 0, nan_count_out 0. in_ready_out is 1 in the first cycle after reset.
- Reset mid-operation drops all in-flight beats; no partial update of sticky flags or counter.
- Class mask bits:
  - 0 -inf, 1 -normal, 2 -subnormal, 3 -zero, 4 +zero, 5 +subnormal, 6 +normal, 7 +inf, 8 signaling NaN, 9 quiet NaN.
  - Exactly one bit is set per lane.
  - NaN classification ignores the sign bit.
- IEEE rules (every format not listed below, including E5M2):
  - exp all-ones, mant 0 -> inf.
  - exp all-ones, mant MSB 1 -> qNaN.
  - exp all-ones, mant MSB 0 and mant != 0 -> sNaN.
  - exp 0, mant 0 -> zero.
  - exp 0, mant != 0 -> subnormal.
  - otherwise -> normal.
- E4M3: no inf. Exp all-ones with mant all-ones -> qNaN. Exp all-ones with any other mantissa -> normal. Never sNaN.
- E2M3, E3M2, E2M1: no inf or NaN. Exp all-ones -> normal.
- Format detection is elaborated from the parameters; no runtime mode.
- Pipeline:
  - Stage 1 registers per-lane field decode: exp_zero, exp_ones, mant_zero, mant_msb, mant_ones, sign.
  - Stage 2 registers class masks, any-NaN, and per-beat flag contributions.
  - Latency is 2 cycles from accepted input to out_valid_out with no backpressure.
  - Throughput is 1 beat/cycle.
- Handshake:
  - Stage k advances when it is empty or its successor advances.
  - in_ready_out = !s1_valid || s1_advance, combinational from out_ready_in.
  - Output data holds stable while out_valid_out && !out_ready_in.
  - No beat is dropped or duplicated.
- Sticky flags and counter update only on output handshake (out_valid_out && out_ready_in), OR-ing that beat's lane classes.
- nan_count_out adds the popcount of NaN lanes in the handshaked beat and saturates at all-ones; it never wraps.
- clr_sticky_in and a handshake in the same cycle: result = that beat's contribution only. The clear applies to old state; the new beat still counts.

Decomposition:
- Shared package fp_class_pkg holds:
  - localparam CLASS_W = 10.
  - Bit-index constants CLASS_NEG_INF … CLASS_QNAN.
  - Enum fp_fmt_e {FMT_IEEE, FMT_E4M3, FMT_E2M3, FMT_E3M2, FMT_E2M1}.
  - A function mapping (EXPONENT_WIDTH, MANTISSA_WIDTH) to fp_fmt_e.
- One sub-module fp_lane_classify: combinational decode plus class encode for a single lane, instantiated NUM_LANES times in a generate loop. The pipeline registers, handshake, sticky flags and counter stay in the top.

Test Plan:
- FP32, NUM_LANES=4, input {0x7F800000, 0xFF800001, 0x7FC00000, 0x00000001}, out_ready_in=1 -> two cycles later the masks are {bit7, bit8, bit9, bit5}, out_any_nan_out=1, sticky_flags_out=4'b1111, nan_count_out=2.
- FP32, lanes {0x80000000, 0x3F800000, 0xBF800000, 0x007FFFFF} -> masks {bit3, bit6, bit1, bit5}, out_any_nan_out=0, nan_count_out unchanged.
- E4M3 (4,3), lanes {0x7F, 0x78, 0xFF, 0x00} -> masks {bit9, bit6, bit9, bit4}, inf_seen stays 0, snan_seen stays 0.
- Backpressure: stream 5 beats with out_ready_in low for 3 cycles mid-stream -> in_ready_out deasserts once both stages are full, out_class_out is held stable, all 5 beats are delivered in order.
- COUNT_WIDTH=2: deliver 3 beats, each with 2 NaN lanes -> nan_count_out goes 2, 3, 3 (saturates). Then clr_sticky_in in the same cycle as a 1-NaN beat handshake -> nan_count_out=1, flags reflect that beat only.
- Assert rst_in while both stages are full -> next cycle out_valid_out=0, flags=0, nan_count_out=0, in_ready_out=1.
